// File: rtl/elev_pkg.sv
// Shared definitions for the elevator car controller and its scheduler.
package elev_pkg;

  localparam int DEFAULT_FLOOR_W = 16;

  // Direction encoding shared with the scheduler's dir bit.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_MOVING       = 2'd1,
    ST_DOOR_OPEN    = 2'd2,
    ST_DOOR_CLOSING = 2'd3
  } car_state_t;

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module elev_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: moves the car toward the scheduler's target one
// floor at a time and sequences the door on arrival.
module elevator_car_ctrl
  import elev_pkg::*;
#(
  parameter int FLOOR_W       = DEFAULT_FLOOR_W,
  parameter int NUM_FLOORS    = 16,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 12,
  parameter int CLOSE_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOOR_W-1:0] target_floor,
  input  logic               target_valid,
  input  logic               door_hold,
  output logic [FLOOR_W-1:0] current_floor,
  output logic               moving_up,
  output logic               moving_down,
  output logic               door_open,
  output logic               door_closing,
  output logic               arrived,
  output logic [FLOOR_W-1:0] served_floor,
  output logic               target_err,
  output car_state_t         state
);

  localparam int DOOR_MAX = (DOOR_CYCLES > CLOSE_CYCLES) ? DOOR_CYCLES : CLOSE_CYCLES;
  localparam int TRV_W    = $clog2(TRAVEL_CYCLES + 1);
  localparam int DOOR_W   = $clog2(DOOR_MAX + 1);

  localparam logic [FLOOR_W-1:0] MAX_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [TRV_W-1:0]   TRV_LOAD   = TRV_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]  DOOR_LOAD  = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [DOOR_W-1:0]  CLOSE_LOAD = DOOR_W'(CLOSE_CYCLES - 1);

  car_state_t         state_q, state_d;
  logic [FLOOR_W-1:0] tgt_q, tgt_d;
  logic [FLOOR_W-1:0] floor_d, served_d, new_tgt;
  logic               dir_q, dir_d;
  logic               arrived_d, err_d;
  logic               in_range, accept;
  logic               trv_load, trv_expired;
  logic               door_load, door_expired;
  logic [DOOR_W-1:0]  door_load_val;

  // Timers are loaded with N-1 so a phase spans exactly N clock edges.
  elev_timer #(.W(TRV_W)) u_travel_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (trv_load),
    .load_val (TRV_LOAD),
    .expired  (trv_expired)
  );

  elev_timer #(.W(DOOR_W)) u_door_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (door_load),
    .load_val (door_load_val),
    .expired  (door_expired)
  );

  function automatic logic [FLOOR_W-1:0] step_floor(input logic [FLOOR_W-1:0] f,
                                                    input logic               dir);
    logic [FLOOR_W-1:0] r;
    if (dir == DIR_UP) begin
      r = (f >= MAX_FLOOR) ? MAX_FLOOR : f + FLOOR_W'(1);
    end else begin
      r = (f == '0) ? '0 : f - FLOOR_W'(1);
    end
    return r;
  endfunction

  // target_valid/target_floor is a level interface with no ready: the value is
  // taken only on an edge where the FSM can act on it (IDLE, or a floor
  // boundary in MOVING); at every other edge it is dropped, not queued.
  assign in_range = (target_floor <= MAX_FLOOR);
  assign accept   = target_valid && in_range;

  always_comb begin
    state_d       = state_q;
    floor_d       = current_floor;
    tgt_d         = tgt_q;
    dir_d         = dir_q;
    served_d      = served_floor;
    err_d         = target_err;
    arrived_d     = 1'b0;
    trv_load      = 1'b0;
    door_load     = 1'b0;
    door_load_val = DOOR_LOAD;
    new_tgt       = tgt_q;

    if (target_valid && !in_range) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (target_floor == current_floor) begin
            state_d   = ST_DOOR_OPEN;
            arrived_d = 1'b1;
            served_d  = current_floor;
            door_load = 1'b1;
          end else begin
            state_d  = ST_MOVING;
            tgt_d    = target_floor;
            dir_d    = (target_floor > current_floor) ? DIR_UP : DIR_DOWN;
            trv_load = 1'b1;
          end
        end
      end

      ST_MOVING: begin
        // Retargeting and reversal are only considered at a floor boundary.
        if (trv_expired) begin
          floor_d = step_floor(current_floor, dir_q);
          new_tgt = accept ? target_floor : tgt_q;
          tgt_d   = new_tgt;
          if (floor_d == new_tgt) begin
            state_d   = ST_DOOR_OPEN;
            arrived_d = 1'b1;
            served_d  = floor_d;
            door_load = 1'b1;
          end else begin
            dir_d    = (new_tgt > floor_d) ? DIR_UP : DIR_DOWN;
            trv_load = 1'b1;
          end
        end
      end

      ST_DOOR_OPEN: begin
        if (door_hold) begin
          door_load = 1'b1;
        end else if (door_expired) begin
          state_d       = ST_DOOR_CLOSING;
          door_load     = 1'b1;
          door_load_val = CLOSE_LOAD;
        end
      end

      ST_DOOR_CLOSING: begin
        if (door_hold) begin
          state_d   = ST_DOOR_OPEN;
          door_load = 1'b1;
        end else if (door_expired) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      current_floor <= '0;
      tgt_q         <= '0;
      dir_q         <= DIR_UP;
      served_floor  <= '0;
      target_err    <= 1'b0;
      arrived       <= 1'b0;
      moving_up     <= 1'b0;
      moving_down   <= 1'b0;
      door_open     <= 1'b0;
      door_closing  <= 1'b0;
    end else begin
      state_q       <= state_d;
      current_floor <= floor_d;
      tgt_q         <= tgt_d;
      dir_q         <= dir_d;
      served_floor  <= served_d;
      target_err    <= err_d;
      arrived       <= arrived_d;
      moving_up     <= (state_d == ST_MOVING) && (dir_d == DIR_UP);
      moving_down   <= (state_d == ST_MOVING) && (dir_d == DIR_DOWN);
      door_open     <= (state_d == ST_DOOR_OPEN);
      door_closing  <= (state_d == ST_DOOR_CLOSING);
    end
  end

  assign state = state_q;

endmodule

// File: doc/elevator_car_ctrl.md
# elevator_car_ctrl

Downstream stage of the request sorter/scheduler. Consumes the scheduler's `nextfloor` target, moves the car one floor at a time with a fixed per-floor travel time, and runs the door open/close sequence on arrival. It produces the `current_floor` value fed back to the scheduler, plus a one-cycle `arrived` pulse so the request slot for the served floor can be cleared.

## Interface
- `FLOOR_W`, 16: width of floor numbers; matches the scheduler's 16-bit floor bus.
- `NUM_FLOORS`, 16: valid floors are 0..NUM_FLOORS-1.
- `TRAVEL_CYCLES`, 8: cycles to travel one floor (≥1).
- `DOOR_CYCLES`, 12: cycles the door stays fully open (≥1).
- `CLOSE_CYCLES`, 4: cycles of the door-closing phase (≥1).

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `target_floor`  in  FLOOR_W  scheduler `nextfloor`.
- `target_valid`  in  1  `target_floor` is meaningful this cycle.
- `door_hold`  in  1  door-reopen/hold button.
- `current_floor`  out  FLOOR_W  registered car position.
- `moving_up`, `moving_down`  out  1  car in motion, by direction; never both high.
- `door_open`  out  1  high in DOOR_OPEN.
- `door_closing`  out  1  high in DOOR_CLOSING.
- `arrived`  out  1  one-cycle pulse on stopping at a floor.
- `served_floor`  out  FLOOR_W  floor stopped at; valid while `arrived` is high, held otherwise.
- `target_err`  out  1  sticky; set when a valid out-of-range target is seen. Cleared only by `rst`.

## Operation
- States: IDLE, MOVING, DOOR_OPEN, DOOR_CLOSING.
- A target is accepted only if `target_valid` is high and `target_floor < NUM_FLOORS`. A valid out-of-range target sets `target_err` and is otherwise ignored.
- IDLE:
  - Accepted target equal to `current_floor` goes to DOOR_OPEN and pulses `arrived`.
  - Accepted target not equal to `current_floor` latches the target and direction, then goes to MOVING.
- MOVING:
  - `travel_cnt` counts TRAVEL_CYCLES cycles per floor.
  - When it expires (the floor boundary), `current_floor` steps ±1 and the counter reloads.
  - At each boundary, an accepted target replaces the latched target and the direction is recomputed. Reversal is allowed only at a boundary.
  - If the new floor equals the latched target, go to DOOR_OPEN, pulse `arrived`, and set `served_floor = new floor`.
- DOOR_OPEN:
  - Lasts DOOR_CYCLES cycles.
  - `door_hold` reloads the door timer, so the door stays open while held.
  - On expiry, go to DOOR_CLOSING.
- DOOR_CLOSING:
  - Lasts CLOSE_CYCLES cycles.
  - `door_hold` returns to DOOR_OPEN with a full DOOR_CYCLES reload; no `arrived` pulse.
  - On expiry, go to IDLE.
- Targets are ignored in the door states. The car never moves with the door open or closing.
- Floor arithmetic saturates at 0 and NUM_FLOORS-1. Because targets are range-checked, saturation is defensive only.
- Reset, at any time including mid-move or mid-door:
  - state IDLE, `current_floor` = 0;
  - all flags 0, `served_floor` = 0;
  - timers cleared, `target_err` = 0.

## Timing
- All outputs are registered.
- Accept in IDLE at edge E:
  - MOVING from E+1.
  - `moving_*` high from E+1.
  - Floor k steps away is reached at edge E+1+k·TRAVEL_CYCLES. At that same edge `arrived`, `door_open` and the state change take effect, and `moving_*` drops.
- Door sequence after arrival at edge A:
  - `door_open` is high for edges A..A+DOOR_CYCLES-1.
  - `door_closing` is high for the next CLOSE_CYCLES edges.
  - IDLE at A+DOOR_CYCLES+CLOSE_CYCLES; a new target can be accepted on that cycle.
- Target equal to the current floor in IDLE at edge E: `door_open` and `arrived` at E+1.
- Simultaneous `door_hold` and door-timer expiry: the hold wins and the timer reloads.
- Simultaneous `rst` and any other event: reset wins.

## Structure
- Shared package `elev_pkg` holds:
  - state enum `car_state_t`;
  - `FLOOR_W` default;
  - direction constants `DIR_UP`/`DIR_DOWN`, shared with the scheduler's `dir` encoding (1 = up).
- Sub-module `elev_timer`: loadable down-counter with `load`, `load_val`, and an `expired` output. It is instantiated twice, once for travel and once for door/closing.

## Test plan
Bench parameters: TRAVEL_CYCLES=4, DOOR_CYCLES=6, CLOSE_CYCLES=2.

1. Reset, then target 3 valid at edge 0:
   - `moving_up` high at edges 1..12.
   - `current_floor` 1/2/3 at edges 5/9/13.
   - `arrived`=1 with `served_floor`=3 at edge 13.
   - `door_open` 13..18, `door_closing` 19..20, IDLE at 21.
2. From floor 3, target 0:
   - `moving_down` high.
   - Floor reaches 0 after 12 moving cycles; `arrived` with `served_floor`=0.
3. Target 5 while moving up from floor 0, changed to 1 during cycle 2: car stops at floor 1 (edge 5) and `arrived` pulses. Changing to 0 at the same point instead reverses the car at floor 1.
4. `door_hold` high for 10 cycles mid-DOOR_OPEN keeps `door_open` high throughout, then 6 more cycles. `door_hold` pulsed during DOOR_CLOSING returns to `door_open`, with no second `arrived`.
5. Target 20 (≥ NUM_FLOORS) valid in IDLE: `target_err`=1 and sticky; state stays IDLE and `current_floor` is unchanged. Target equal to `current_floor` gives `arrived` and `door_open` one cycle later.
6. `rst` asserted at edge 7 of scenario 1: on the next edge `current_floor`=0, IDLE, all outputs 0; the car then accepts a new target normally.
